// File: rtl/display_scan_ctrl_if.sv
// Bus bundle for display_scan_ctrl: load/value handshake in, scan and digit data out.
interface display_scan_ctrl_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        busy;
    logic [1:0]  digit;
    logic [4:0]  d0;
    logic [4:0]  d1;
    logic [4:0]  d2;
    logic [4:0]  d3;
    logic        frame;

    modport master (output load, value, dp_in,
                    input  busy, digit, d0, d1, d2, d3, frame);
    modport slave  (input  load, value, dp_in,
                    output busy, digit, d0, d1, d2, d3, frame);
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed display scan controller with frame-synchronous, tear-free digit update.
// Optional macro BCD_CONV_EN: binary-to-BCD (double-dabble) conversion of the loaded value.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               reset,
    display_scan_ctrl_if.slave bus
);
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc;
    logic [1:0]    digit_q;
    logic          frame_q;
    logic          tc;
    logic          frame_edge;

    logic [3:0]    pend_dp;
    logic [15:0]   pend_nib;
    logic          pend_valid;
    logic [4:0]    d0_q, d1_q, d2_q, d3_q;

    logic          wr_pend;
    logic [15:0]   wr_nib;
    logic [3:0]    wr_dp;

    assign tc         = (presc == PW'(REFRESH_DIV - 1));
    assign frame_edge = tc && (digit_q == 2'd3);

    // Free-running scan: prescaler, digit index and frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            digit_q <= 2'd0;
            frame_q <= 1'b0;
        end else begin
            presc   <= tc ? '0 : presc + PW'(1);
            frame_q <= frame_edge;
            if (tc) digit_q <= digit_q + 2'd1;
        end
    end

`ifdef BCD_CONV_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    logic [0:0]  state, state_nxt;
    logic [3:0]  cnt;
    logic [15:0] bin_sr;
    logic [15:0] bcd_sr;
    logic [15:0] bcd_adj;
    logic [15:0] bcd_step;
    logic        err_q;
    logic [3:0]  dp_cap;
    logic        busy_q;
    logic        conv_done;
    logic        accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Add-3 correction per BCD nibble, then shift in the next binary bit
    always_comb begin
        state_nxt = state;
        conv_done = 1'b0;
        accept    = 1'b0;
        bcd_adj   = bcd_sr;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[14:0], bin_sr[15]};
        case (state)
            ST_IDLE: if (bus.load) begin
                accept    = 1'b1;
                state_nxt = ST_CONV;
            end
            ST_CONV: if (cnt == 4'd15) begin
                conv_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 4'd0;
            bin_sr <= 16'd0;
            bcd_sr <= 16'd0;
            err_q  <= 1'b0;
            dp_cap <= 4'd0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == ST_CONV);
            if (accept) begin
                cnt    <= 4'd0;
                bin_sr <= bus.value;
                bcd_sr <= 16'd0;
                err_q  <= (bus.value > 16'd9999);
                dp_cap <= bus.dp_in;
            end else if (state == ST_CONV) begin
                cnt    <= cnt + 4'd1;
                bin_sr <= {bin_sr[14:0], 1'b0};
                bcd_sr <= bcd_step;
            end
        end
    end

    assign wr_pend  = conv_done;
    assign wr_nib   = err_q ? 16'hEEEE : bcd_step;
    assign wr_dp    = dp_cap;
    assign bus.busy = busy_q;
`else
    assign wr_pend  = bus.load;
    assign wr_nib   = bus.value;
    assign wr_dp    = bus.dp_in;
    assign bus.busy = 1'b0;
`endif

    // Pending buffer; a write on a frame edge wins over the commit's clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_nib   <= 16'd0;
            pend_dp    <= 4'd0;
            pend_valid <= 1'b0;
        end else if (wr_pend) begin
            pend_nib   <= wr_nib;
            pend_dp    <= wr_dp;
            pend_valid <= 1'b1;
        end else if (frame_edge) begin
            pend_valid <= 1'b0;
        end
    end

    // Displayed digits change only on a frame edge, from the pre-edge pending contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_q <= 5'd0;
            d1_q <= 5'd0;
            d2_q <= 5'd0;
            d3_q <= 5'd0;
        end else if (frame_edge && pend_valid) begin
            d0_q <= {pend_dp[0], pend_nib[3:0]};
            d1_q <= {pend_dp[1], pend_nib[7:4]};
            d2_q <= {pend_dp[2], pend_nib[11:8]};
            d3_q <= {pend_dp[3], pend_nib[15:12]};
        end
    end

    assign bus.digit = digit_q;
    assign bus.frame = frame_q;
    assign bus.d0    = d0_q;
    assign bus.d1    = d1_q;
    assign bus.d2    = d2_q;
    assign bus.d3    = d3_q;
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit is held before the scan advances (minimum 2).
REQ-002 clk  in  1  single system clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 load  in  1  one-cycle strobe; requests capture of value and dp_in.
REQ-005 value  in  16  display value; hex nibbles, or a binary integer when BCD_CONV_EN is defined.
REQ-006 dp_in  in  4  decimal-point enables; bit i belongs to digit i.
REQ-007 busy  out  1  high while a captured value is being converted; loads are ignored while high.
REQ-008 digit  out  2  currently scanned digit index, for the downstream digit decoder.
REQ-009 d0, d1, d2, d3  out  5 each  {dp, nibble} for digit 0..3, for the downstream digit decoder.
REQ-010 frame  out  1  one-cycle pulse on the cycle in which digit wraps from 3 to 0.

Function
REQ-011 Prescaler: shall count 0..REFRESH_DIV-1 and wrap to 0; the terminal count is tc.
REQ-012 On tc, digit shall increment modulo 4 (3 -> 0).
REQ-013 frame shall be asserted exactly on the clk edge where digit goes 3 -> 0, giving one pulse per 4*REFRESH_DIV cycles.
REQ-014 Pending register: holds {dp_in, converted nibbles} plus a pend_valid flag.
REQ-015 Frame commit: on a frame edge with pend_valid=1, pending shall be copied into d0..d3 and pend_valid cleared; d0..d3 shall change at no other time (no tearing within a frame).
REQ-016 A load with busy=0 is accepted; a load with busy=1 shall be dropped silently.
REQ-017 Load and frame edge on the same cycle: the commit shall use the pending contents from before the load; the new value sets pend_valid and is committed at the next frame (set wins over clear).
REQ-018 Back-to-back accepted loads before a frame: the last accepted value shall overwrite pending; earlier values are never displayed.
REQ-019 Nibble order: d0 = value[3:0] (least significant digit, rightmost), d3 = most significant digit.
REQ-020 The digit/prescaler scan shall run continuously and is unaffected by load or busy.

Reset
REQ-021 On reset asserted, all of the following shall be 0 immediately, without waiting for clk: prescaler, digit, d0..d3 (5'b00000), pending register, pend_valid, busy, frame.
REQ-022 reset mid-conversion or mid-frame shall abort all work; the first frame pulse after release shall occur 4*REFRESH_DIV cycles after the first clk edge following release.

Configuration
REQ-023 Macro BCD_CONV_EN is undefined (default):
- value nibbles pass straight through to pending on the edge that accepts load.
- busy is tied to 0.
REQ-024 Macro BCD_CONV_EN is defined:
- value is treated as unsigned binary and converted by a sequential shift-add-3 (double-dabble) converter, one bit per cycle.
- busy rises the cycle after the accepting edge and stays high for exactly 16 cycles.
- pending and pend_valid are written on the edge on which busy falls.
REQ-025 With BCD_CONV_EN defined and value > 9999, all four nibbles shall be 4'hE (error display); dp_in is still honoured.

Verification
REQ-026 Reset release, REFRESH_DIV=4 -> digit sequence 0,1,2,3,0 advancing every 4 cycles; frame pulses on cycles 16, 32, 48.
REQ-027 No macro; load value=16'h1A2F, dp_in=4'b0100 mid-frame -> d0..d3 stay 0 until the next frame edge, then d0=5'h0F, d1=5'h02, d2=5'h1A, d3=5'h01.
REQ-028 No macro; load 16'h1111 on a frame-edge cycle while pending holds 16'h2222 -> 2222 is shown for one frame, then 1111.
REQ-029 BCD_CONV_EN defined; load value=1234 -> busy high for 16 cycles, second load during busy ignored; at the following frame d3..d0 nibbles = 1,2,3,4.
REQ-030 BCD_CONV_EN defined; load value=10000 -> d3..d0 nibbles = E,E,E,E after commit. Then assert reset mid-conversion -> all outputs 0 asynchronously; no commit of the aborted value.
